// File: rtl/ysyx_22041207_mem_arbiter.sv
// ysyx_22041207_mem_arbiter
// Shares one AXI-style memory port between instruction fetch (read-only) and the
// load/store stage (read or write). One slave transaction is in flight at a time.
// Optional feature macro: ARB_RR_EN -- round-robin between IF and MEM when both
// requests are pending; otherwise MEM has fixed priority over IF.
module ysyx_22041207_mem_arbiter #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic                  if_done,
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [ADDR_W-1:0]     mem_addr,
   input  logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W/8-1:0]   mem_wmask,
   input  logic [3:0]            mem_size,
   output logic                  mem_done,
   output logic [DATA_W-1:0]     rdata,
   output logic                  s_r_valid,
   input  logic                  s_r_ready,
   output logic [ADDR_W-1:0]     s_r_addr,
   output logic [7:0]            s_r_size,
   input  logic                  s_d_valid,
   output logic                  s_d_ready,
   input  logic [DATA_W-1:0]     s_d_data,
   output logic                  s_w_valid,
   input  logic                  s_w_ready,
   output logic [ADDR_W-1:0]     s_w_addr,
   output logic [DATA_W-1:0]     s_w_data,
   output logic [DATA_W/8-1:0]   s_w_mask,
   input  logic                  s_b_valid,
   output logic                  s_b_ready
);

   localparam int unsigned MASK_W = DATA_W / 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RADDR = 3'd1,
      S_RDATA = 3'd2,
      S_WADDR = 3'd3,
      S_WRESP = 3'd4
   } state_t;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_t;

   state_t              state, state_n;
   owner_t              owner, owner_n;
   logic                grant_mem;
   logic                if_done_n, mem_done_n;
   logic [DATA_W-1:0]   rdata_n;
   logic                s_r_valid_n, s_d_ready_n, s_w_valid_n, s_b_ready_n;
   logic [ADDR_W-1:0]   s_r_addr_n, s_w_addr_n;
   logic [7:0]          s_r_size_n;
   logic [DATA_W-1:0]   s_w_data_n;
   logic [MASK_W-1:0]   s_w_mask_n;
`ifdef ARB_RR_EN
   owner_t              last_grant, last_grant_n;
`endif

   // State, owner and every registered output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         owner     <= OWN_IF;
         if_done   <= 1'b0;
         mem_done  <= 1'b0;
         rdata     <= '0;
         s_r_valid <= 1'b0;
         s_r_addr  <= '0;
         s_r_size  <= '0;
         s_d_ready <= 1'b0;
         s_w_valid <= 1'b0;
         s_w_addr  <= '0;
         s_w_data  <= '0;
         s_w_mask  <= '0;
         s_b_ready <= 1'b0;
`ifdef ARB_RR_EN
         last_grant <= OWN_IF;
`endif
      end else begin
         state     <= state_n;
         owner     <= owner_n;
         if_done   <= if_done_n;
         mem_done  <= mem_done_n;
         rdata     <= rdata_n;
         s_r_valid <= s_r_valid_n;
         s_r_addr  <= s_r_addr_n;
         s_r_size  <= s_r_size_n;
         s_d_ready <= s_d_ready_n;
         s_w_valid <= s_w_valid_n;
         s_w_addr  <= s_w_addr_n;
         s_w_data  <= s_w_data_n;
         s_w_mask  <= s_w_mask_n;
         s_b_ready <= s_b_ready_n;
`ifdef ARB_RR_EN
         last_grant <= last_grant_n;
`endif
      end
   end

   // Arbitration, handshake sequencing and next values of registered outputs
   always_comb begin
      state_n     = state;
      owner_n     = owner;
      if_done_n   = 1'b0;
      mem_done_n  = 1'b0;
      rdata_n     = rdata;
      s_r_valid_n = s_r_valid;
      s_r_addr_n  = s_r_addr;
      s_r_size_n  = s_r_size;
      s_d_ready_n = s_d_ready;
      s_w_valid_n = s_w_valid;
      s_w_addr_n  = s_w_addr;
      s_w_data_n  = s_w_data;
      s_w_mask_n  = s_w_mask;
      s_b_ready_n = s_b_ready;
`ifdef ARB_RR_EN
      last_grant_n = last_grant;
      grant_mem    = mem_req && (!if_req || (last_grant == OWN_IF));
`else
      grant_mem    = mem_req;
`endif

      unique case (state)
         S_IDLE: begin
            // Holding off while a done pulse is out stops a still-high request re-granting
            if (!if_done && !mem_done) begin
               if (grant_mem) begin
                  owner_n = OWN_MEM;
`ifdef ARB_RR_EN
                  last_grant_n = OWN_MEM;
`endif
                  if (mem_we) begin
                     if (mem_wmask == '0) begin
                        mem_done_n = 1'b1;
                     end else begin
                        s_w_valid_n = 1'b1;
                        s_w_addr_n  = mem_addr;
                        s_w_data_n  = mem_wdata;
                        s_w_mask_n  = mem_wmask;
                        state_n     = S_WADDR;
                     end
                  end else begin
                     s_r_valid_n = 1'b1;
                     s_r_addr_n  = mem_addr;
                     s_r_size_n  = {4'b0, mem_size};
                     state_n     = S_RADDR;
                  end
               end else if (if_req) begin
                  owner_n     = OWN_IF;
`ifdef ARB_RR_EN
                  last_grant_n = OWN_IF;
`endif
                  s_r_valid_n = 1'b1;
                  s_r_addr_n  = if_addr;
                  s_r_size_n  = 8'd8;
                  state_n     = S_RADDR;
               end
            end
         end
         S_RADDR: begin
            if (s_r_valid && s_r_ready) begin
               s_r_valid_n = 1'b0;
               s_d_ready_n = 1'b1;
               state_n     = S_RDATA;
            end
         end
         S_RDATA: begin
            if (s_d_valid && s_d_ready) begin
               rdata_n     = s_d_data;
               s_d_ready_n = 1'b0;
               if (owner == OWN_MEM) mem_done_n = 1'b1;
               else                  if_done_n  = 1'b1;
               state_n     = S_IDLE;
            end
         end
         S_WADDR: begin
            if (s_w_valid && s_w_ready) begin
               s_w_valid_n = 1'b0;
               s_b_ready_n = 1'b1;
               state_n     = S_WRESP;
            end
         end
         S_WRESP: begin
            if (s_b_valid && s_b_ready) begin
               s_b_ready_n = 1'b0;
               mem_done_n  = 1'b1;
               state_n     = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule
